// File: rtl/cr_huf_comp_bit_pack_pkg.sv
// Shared types and sizing for the Huffman compressor bit packer.
package cr_huf_comp_pack_pkg;

    localparam int CODE_W = 48;
    localparam int LEN_W  = 6;
    localparam int OUT_W  = 64;
    localparam int ACC_W  = 2 * OUT_W;
    localparam int FILL_W = $clog2(ACC_W) + 1;
    localparam int BITS_W = $clog2(OUT_W) + 1;

    typedef struct packed {
        logic              eob;
        logic [LEN_W-1:0]  len;
        logic [CODE_W-1:0] code;
    } entry_t;

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

endpackage

// File: rtl/cr_huf_comp_bit_pack_if.sv
// Symbol FIFO pop port and packed-word output stream.
interface cr_huf_comp_bit_pack_fifo_if;
    import cr_huf_comp_pack_pkg::*;

    logic   fifo_empty;
    entry_t fifo_rdata;
    logic   fifo_rerr;
    logic   fifo_ren;

    modport master (
        output fifo_empty, fifo_rdata, fifo_rerr,
        input  fifo_ren
    );
    modport slave (
        input  fifo_empty, fifo_rdata, fifo_rerr,
        output fifo_ren
    );
endinterface

interface cr_huf_comp_bit_pack_out_if;
    import cr_huf_comp_pack_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [BITS_W-1:0] out_bits;
    logic              out_last;
    logic              out_err;

    modport master (
        output out_valid, out_data, out_bits, out_last, out_err,
        input  out_ready
    );
    modport slave (
        input  out_valid, out_data, out_bits, out_last, out_err,
        output out_ready
    );
endinterface

// File: rtl/cr_huf_comp_bit_pack_merge.sv
// Masks a codeword to its length and ORs it into an accumulator at an offset.
module cr_huf_comp_bit_pack_merge
    import cr_huf_comp_pack_pkg::*;
(
    input  logic [ACC_W-1:0]  acc,
    input  logic [CODE_W-1:0] code,
    input  logic [LEN_W-1:0]  len,
    input  logic [FILL_W-1:0] offset,
    output logic [ACC_W-1:0]  merged
);

    logic [CODE_W-1:0] mask;

    always_comb begin
        mask = '0;
        for (int i = 0; i < CODE_W; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
    end

    assign merged = acc | ({{(ACC_W-CODE_W){1'b0}}, code & mask} << offset);

endmodule

// File: rtl/cr_huf_comp_bit_pack.sv
// Packs variable-length codewords LSB-first into OUT_W-bit words,
// flushing a partial last word at end of block.
module cr_huf_comp_bit_pack
    import cr_huf_comp_pack_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    cr_huf_comp_bit_pack_fifo_if.slave fifo,
    cr_huf_comp_bit_pack_out_if.master out
);

    localparam logic [FILL_W-1:0] OUT_F  = FILL_W'(OUT_W);
    localparam logic [LEN_W-1:0]  CODE_L = LEN_W'(CODE_W);
    localparam logic [BITS_W-1:0] OUT_B  = BITS_W'(OUT_W);

    state_t            state, state_nx;
    logic [ACC_W-1:0]  acc, acc_nx, acc_sh, merged;
    logic [FILL_W-1:0] fill, fill_nx, fill_sh;
    logic              err_sticky, err_nx;
    logic              rst_done;

    logic              valid, last, fire, drop, ren;
    logic [BITS_W-1:0] bits;
    logic [OUT_W-1:0]  dmask;
    logic [LEN_W-1:0]  len_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            acc        <= '0;
            fill       <= '0;
            err_sticky <= 1'b0;
            rst_done   <= 1'b0;
        end else begin
            state      <= state_nx;
            acc        <= acc_nx;
            fill       <= fill_nx;
            err_sticky <= err_nx;
            rst_done   <= 1'b1;
        end
    end

    // Presentation: nothing is reported while no word is on offer.
    always_comb begin
        valid = 1'b0;
        last  = 1'b0;
        bits  = '0;
        unique case (state)
            RUN: begin
                valid = (fill >= OUT_F);
                bits  = valid ? OUT_B : '0;
            end
            FLUSH: begin
                valid = 1'b1;
                bits  = OUT_B;
                if (fill <= OUT_F) begin
                    last = 1'b1;
                    bits = fill[BITS_W-1:0];
                end
            end
        endcase
    end

    always_comb begin
        dmask = '0;
        for (int i = 0; i < OUT_W; i++) begin
            dmask[i] = (BITS_W'(i) < bits);
        end
    end

    assign out.out_valid = valid;
    assign out.out_bits  = bits;
    assign out.out_last  = last;
    assign out.out_err   = err_sticky;
    assign out.out_data  = acc[OUT_W-1:0] & dmask;

    assign fire    = valid && out.out_ready;
    assign drop    = fire && !last;
    assign acc_sh  = drop ? (acc >> OUT_W) : acc;
    assign fill_sh = drop ? (fill - OUT_F) : fill;
    assign len_c   = (fifo.fifo_rdata.len > CODE_L) ? CODE_L : fifo.fifo_rdata.len;

    // Popping only below one word of backlog keeps fill under ACC_W.
    assign ren = rst_done && (state == RUN) && !fifo.fifo_empty && (fill_sh < OUT_F);
    assign fifo.fifo_ren = ren;

    cr_huf_comp_bit_pack_merge u_merge (
        .acc    (acc_sh),
        .code   (fifo.fifo_rdata.code),
        .len    (len_c),
        .offset (fill_sh),
        .merged (merged)
    );

    always_comb begin
        state_nx = state;
        acc_nx   = acc_sh;
        fill_nx  = fill_sh;
        err_nx   = err_sticky;
        if (fire && last) begin
            state_nx = RUN;
            acc_nx   = '0;
            fill_nx  = '0;
            err_nx   = 1'b0;
        end else if (ren) begin
            acc_nx  = merged;
            fill_nx = fill_sh + {{(FILL_W-LEN_W){1'b0}}, len_c};
            err_nx  = err_sticky | fifo.fifo_rerr;
            if (fifo.fifo_rdata.eob) begin
                state_nx = FLUSH;
            end
        end
    end

    a_len_legal: assert property (
        @(posedge clk) disable iff (!rst_n)
        ren |-> (fifo.fifo_rdata.len <= CODE_L)
    );

endmodule

// File: tb/tb_cr_huf_comp_bit_pack.sv
// Randomized bench for the bit packer against a bit-queue reference model.
module tb_cr_huf_comp_bit_pack;
    import cr_huf_comp_pack_pkg::*;

    typedef struct {
        bit                eob;
        int                len;
        logic [CODE_W-1:0] code;
        bit                rerr;
    } ent_t;

    typedef struct {
        logic [OUT_W-1:0] data;
        int               bits;
        bit               last;
        bit               err;
    } wd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    cr_huf_comp_bit_pack_fifo_if fif();
    cr_huf_comp_bit_pack_out_if  oif();

    cr_huf_comp_bit_pack dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fifo  (fif.slave),
        .out   (oif.master)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    ent_t fq[$];
    ent_t mblk[$];
    wd_t  got[$];
    wd_t  exq[$];
    bit   mbq[$];
    int   mpos = 0;
    int   mserr = -1;
    int   gap_pct = 0;
    int   rdy_pct = 100;
    bit   rdy_low = 0;
    bit   rst_evt = 0;
    bit   prev_stall = 0;
    wd_t  prev_w;
    int   pops = 0;

    always @(negedge rst_n) rst_evt = 1;

    // FIFO/ready driver and per-cycle protocol monitor.
    always @(negedge clk) begin
        wd_t cur;
        #1;
        if (fq.size() > 0 && $urandom_range(99) >= gap_pct) begin
            fif.fifo_empty = 1'b0;
            fif.fifo_rdata = {fq[0].eob, LEN_W'(fq[0].len), fq[0].code};
            fif.fifo_rerr  = fq[0].rerr;
        end else begin
            fif.fifo_empty = 1'b1;
            fif.fifo_rdata = '0;
            fif.fifo_rerr  = 1'b0;
        end
        oif.out_ready = !rdy_low && ($urandom_range(99) < rdy_pct);
        #3;
        cur.data = oif.out_data;
        cur.bits = int'(oif.out_bits);
        cur.last = oif.out_last;
        cur.err  = oif.out_err;
        if (rst_evt || !rst_n) begin
            prev_stall = 0;
            rst_evt = 0;
        end else if (prev_stall) begin
            checks++;
            if (oif.out_valid !== 1'b1 || cur != prev_w)
                begin errors++; $display("FAIL hold: got v=%b d=%h b=%0d l=%b e=%b exp d=%h b=%0d l=%b e=%b", oif.out_valid, cur.data, cur.bits, cur.last, cur.err, prev_w.data, prev_w.bits, prev_w.last, prev_w.err); end
        end
        if (fif.fifo_ren === 1'b1) begin
            checks++;
            if (fif.fifo_empty) begin errors++; $display("FAIL ren_empty: got ren=1 exp 0"); end
        end
        if (oif.out_valid === 1'b1 && !oif.out_ready) begin
            checks++;
            if (fif.fifo_ren !== 1'b0) begin errors++; $display("FAIL ren_stall: got %b exp 0", fif.fifo_ren); end
        end
        if (fif.fifo_ren === 1'b1 && !fif.fifo_empty) begin
            void'(fq.pop_front());
            pops++;
        end
        if (oif.out_valid === 1'b1 && oif.out_ready) got.push_back(cur);
        prev_stall = rst_n && oif.out_valid === 1'b1 && !oif.out_ready;
        prev_w = cur;
    end

    function automatic ent_t mk(bit eob, int len, logic [CODE_W-1:0] code, bit rerr);
        ent_t e;
        e.eob = eob; e.len = len; e.code = code; e.rerr = rerr;
        return e;
    endfunction

    function automatic void add(ent_t e);
        fq.push_back(e);
        mblk.push_back(e);
    endfunction

    function automatic void emit(bit last);
        wd_t w;
        int n;
        n = last ? mbq.size() : OUT_W;
        w.data = '0;
        for (int i = 0; i < n; i++) w.data[i] = mbq.pop_front();
        w.bits = n;
        w.last = last;
        w.err  = (mserr >= 0) && (last || (mpos + n > mserr));
        mpos += n;
        exq.push_back(w);
    endfunction

    // Bits form one stream per block; whole words leave as soon as they
    // exist, and the end-of-block remainder leaves as at most two words.
    function automatic void model();
        int total = 0;
        foreach (mblk[k]) begin
            if (mblk[k].rerr && mserr < 0) mserr = total;
            for (int b = 0; b < mblk[k].len; b++) mbq.push_back(mblk[k].code[b]);
            total += mblk[k].len;
            if (!mblk[k].eob) begin
                while (mbq.size() >= OUT_W) emit(1'b0);
            end else begin
                while (mbq.size() > OUT_W) emit(1'b0);
                emit(1'b1);
                total = 0; mpos = 0; mserr = -1;
            end
        end
        mblk.delete();
    endfunction

    task automatic wait_got(input int n, input int budget, output bit ok);
        int c = 0;
        while (got.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        repeat (5) @(negedge clk);
        ok = (got.size() >= n);
    endtask

    task automatic test_reset();
        bit ok;
        rst_n = 0; rdy_low = 0; rdy_pct = 100; gap_pct = 0;
        got.delete();
        add(mk(1, 0, 48'h5A5A_5A5A, 0));
        model();
        repeat (3) @(negedge clk);
        #4;
        checks++; if (oif.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", oif.out_valid); end
        checks++; if (oif.out_data !== '0) begin errors++; $display("FAIL rst_data: got %h exp 0", oif.out_data); end
        checks++; if (oif.out_bits !== '0) begin errors++; $display("FAIL rst_bits: got %0d exp 0", oif.out_bits); end
        checks++; if (oif.out_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b exp 0", oif.out_last); end
        checks++; if (oif.out_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", oif.out_err); end
        checks++; if (fif.fifo_ren !== 1'b0) begin errors++; $display("FAIL rst_ren: got %b exp 0", fif.fifo_ren); end
        @(negedge clk);
        #2 rst_n = 1;
        #2;
        checks++; if (fif.fifo_ren !== 1'b0) begin errors++; $display("FAIL ren_first_edge: got %b exp 0", fif.fifo_ren); end
        @(negedge clk);
        #4;
        checks++; if (fif.fifo_ren !== 1'b1) begin errors++; $display("FAIL ren_after_done: got %b exp 1", fif.fifo_ren); end
        wait_got(1, 20, ok);
        checks++;
        if (!ok || got.size() != 1) begin errors++; $display("FAIL zero_len_count: got %0d exp 1", got.size()); end
        else if (got[0] != exq[0]) begin errors++; $display("FAIL zero_len_word: got d=%h b=%0d l=%b exp d=0 b=0 l=1", got[0].data, got[0].bits, got[0].last); end
        exq.delete();
    endtask

    task automatic test_a5();
        bit ok;
        got.delete();
        for (int k = 0; k < 8; k++) add(mk(k == 7, 8, 48'hA5, 0));
        mblk.delete();
        wait_got(1, 60, ok);
        checks++;
        if (!ok || got.size() != 1) begin errors++; $display("FAIL a5_count: got %0d exp 1", got.size()); end
        else begin
            checks++; if (got[0].data !== 64'hA5A5A5A5A5A5A5A5) begin errors++; $display("FAIL a5_data: got %h exp a5a5a5a5a5a5a5a5", got[0].data); end
            checks++; if (got[0].bits != 64 || !got[0].last || got[0].err) begin errors++; $display("FAIL a5_ctl: got b=%0d l=%b e=%b exp b=64 l=1 e=0", got[0].bits, got[0].last, got[0].err); end
        end
    endtask

    task automatic test_long_short();
        bit ok;
        got.delete();
        add(mk(0, 48, 48'h1, 0));
        add(mk(1, 20, 48'hDEADBE_FFFFF, 0));
        mblk.delete();
        wait_got(2, 60, ok);
        checks++;
        if (!ok || got.size() != 2) begin errors++; $display("FAIL ls_count: got %0d exp 2", got.size()); end
        else begin
            checks++; if (got[0].data !== 64'hFFFF_0000_0000_0001 || got[0].bits != 64 || got[0].last)
                begin errors++; $display("FAIL ls_word0: got d=%h b=%0d l=%b exp d=ffff000000000001 b=64 l=0", got[0].data, got[0].bits, got[0].last); end
            checks++; if (got[1].data !== 64'hF || got[1].bits != 4 || !got[1].last)
                begin errors++; $display("FAIL ls_word1: got d=%h b=%0d l=%b exp d=f b=4 l=1", got[1].data, got[1].bits, got[1].last); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int c = 0;
        int p0;
        got.delete(); exq.delete();
        rdy_low = 1; gap_pct = 0; pops = 0;
        for (int k = 0; k < 12; k++) add(mk(k == 11, 16, 48'($urandom), 0));
        model();
        while (oif.out_valid !== 1'b1 && c < 50) begin @(negedge clk); c++; end
        checks++; if (oif.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout: got 0 exp 1"); end
        p0 = pops;
        repeat (10) @(negedge clk);
        checks++; if (pops != p0 || pops != 4) begin errors++; $display("FAIL bp_pops: got %0d/%0d exp 4", p0, pops); end
        checks++; if (pops * 16 > 111 || pops * 16 < 64) begin errors++; $display("FAIL bp_fill: got %0d exp 64..111", pops * 16); end
        rdy_low = 0; rdy_pct = 100;
        wait_got(exq.size(), 100, ok);
        checks++; if (got.size() != exq.size() || fq.size() != 0) begin errors++; $display("FAIL bp_count: got %0d exp %0d", got.size(), exq.size()); end
        foreach (exq[i]) if (i < got.size()) begin
            checks++;
            if (got[i] != exq[i]) begin errors++; $display("FAIL bp_word%0d: got d=%h b=%0d l=%b e=%b exp d=%h b=%0d l=%b e=%b", i, got[i].data, got[i].bits, got[i].last, got[i].err, exq[i].data, exq[i].bits, exq[i].last, exq[i].err); end
        end
    endtask

    task automatic test_error();
        bit ok;
        got.delete(); exq.delete();
        rdy_pct = 70; gap_pct = 20;
        for (int k = 0; k < 20; k++) add(mk(k == 19, 16, 48'($urandom), k == 1));
        for (int k = 0; k < 5; k++) add(mk(k == 4, 16, 48'($urandom), 0));
        model();
        wait_got(exq.size(), 400, ok);
        checks++; if (got.size() != exq.size()) begin errors++; $display("FAIL err_count: got %0d exp %0d", got.size(), exq.size()); end
        foreach (exq[i]) if (i < got.size()) begin
            checks++;
            if (got[i] != exq[i]) begin errors++; $display("FAIL err_word%0d: got d=%h b=%0d l=%b e=%b exp d=%h b=%0d l=%b e=%b", i, got[i].data, got[i].bits, got[i].last, got[i].err, exq[i].data, exq[i].bits, exq[i].last, exq[i].err); end
        end
    endtask

    task automatic test_random();
        bit ok;
        got.delete(); exq.delete();
        for (int b = 0; b < 30; b++) begin
            int n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++)
                add(mk(k == n - 1, $urandom_range(0, CODE_W), {$urandom, $urandom}, $urandom_range(0, 19) == 0));
        end
        model();
        rdy_pct = $urandom_range(50, 100); gap_pct = $urandom_range(0, 40);
        wait_got(exq.size(), 5000, ok);
        checks++; if (got.size() != exq.size()) begin errors++; $display("FAIL rnd_count: got %0d exp %0d", got.size(), exq.size()); end
        foreach (exq[i]) if (i < got.size()) begin
            checks++;
            if (got[i] != exq[i]) begin errors++; $display("FAIL rnd_word%0d: got d=%h b=%0d l=%b e=%b exp d=%h b=%0d l=%b e=%b", i, got[i].data, got[i].bits, got[i].last, got[i].err, exq[i].data, exq[i].bits, exq[i].last, exq[i].err); end
        end
    endtask

    task automatic test_reset_mid_flush();
        bit ok;
        int c = 0;
        got.delete(); exq.delete();
        rdy_low = 1; gap_pct = 0;
        for (int k = 0; k < 4; k++) add(mk(k == 3, 20, 48'($urandom), 0));
        mblk.delete();
        while ((fq.size() != 0 || oif.out_valid !== 1'b1) && c < 50) begin @(negedge clk); c++; end
        repeat (2) @(negedge clk);
        #4;
        checks++; if (oif.out_valid !== 1'b1 || fq.size() != 0) begin errors++; $display("FAIL mf_setup: got v=%b q=%0d exp v=1 q=0", oif.out_valid, fq.size()); end
        rst_n = 0;
        #1;
        checks++; if (oif.out_valid !== 1'b0) begin errors++; $display("FAIL mf_valid: got %b exp 0", oif.out_valid); end
        checks++; if (fif.fifo_ren !== 1'b0) begin errors++; $display("FAIL mf_ren: got %b exp 0", fif.fifo_ren); end
        got.delete();
        for (int k = 0; k < 5; k++) add(mk(k == 4, $urandom_range(1, CODE_W), {$urandom, $urandom}, 0));
        model();
        rdy_low = 0; rdy_pct = 100;
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        #2;
        checks++; if (fif.fifo_ren !== 1'b0) begin errors++; $display("FAIL mf_ren_first_edge: got %b exp 0", fif.fifo_ren); end
        wait_got(exq.size(), 100, ok);
        checks++; if (got.size() != exq.size()) begin errors++; $display("FAIL mf_count: got %0d exp %0d", got.size(), exq.size()); end
        foreach (exq[i]) if (i < got.size()) begin
            checks++;
            if (got[i] != exq[i]) begin errors++; $display("FAIL mf_word%0d: got d=%h b=%0d l=%b e=%b exp d=%h b=%0d l=%b e=%b", i, got[i].data, got[i].bits, got[i].last, got[i].err, exq[i].data, exq[i].bits, exq[i].last, exq[i].err); end
        end
    endtask

    initial begin
        fif.fifo_empty = 1'b1;
        fif.fifo_rdata = '0;
        fif.fifo_rerr  = 1'b0;
        oif.out_ready  = 1'b0;
        test_reset();
        test_a5();
        test_long_short();
        test_backpressure();
        test_error();
        test_random();
        test_reset_mid_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cr_huf_comp_bit_pack.md
Name: cr_huf_comp_bit_pack

Overview:
- Downstream consumer of the Huffman compressor symbol FIFO. It pops variable-length codewords, each tagged with a length and an end-of-block flag.
- Codewords are packed LSB-first into a 128-bit accumulator.
- Full OUT_W-bit words go out on a valid/ready stream to the output framer.
- On end-of-block it flushes a final partial word and reports its valid bit count.

Parameters:
- CODE_W, 48, max codeword width in a FIFO entry.
- LEN_W, 6, width of the codeword length field. Legal lengths are 0..CODE_W.
- OUT_W, 64, output word width. ACC_W = 2*OUT_W (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- fifo_empty  in  1  symbol FIFO empty.
- fifo_rdata  in  CODE_W+LEN_W+1  entry {eob, len, code}. Valid combinationally whenever !fifo_empty.
- fifo_rerr  in  1  ECC error on the current entry.
- fifo_ren  out  1  pop strobe. Combinational, may be high only when !fifo_empty.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- out_data  out  OUT_W  packed bits, LSB first. Unused upper bits are zero.
- out_bits  out  log2(OUT_W)+1  valid bits in out_data: OUT_W, except on the last word of a block.
- out_last  out  1  last word of the block.
- out_err  out  1  block contained an ECC-errored entry.

Behaviour:
- Reset (async, active-low): out_valid=0, out_data=0, out_bits=0, out_last=0, out_err=0, fill=0, accumulator=0, state=RUN, err_sticky=0, rst_done=0.
- rst_done sets on the first clk edge after rst_n deasserts. fifo_ren is forced 0 while rst_done=0.
- fire = out_valid && out_ready. While out_valid && !out_ready, out_data/out_bits/out_last/out_err hold stable.
- out_* are taken combinationally from the accumulator's low OUT_W bits (zeroed above out_bits) and registered state. Zero-latency presentation once fill qualifies.
- RUN state:
  - out_valid = (fill >= OUT_W), out_bits = OUT_W, out_last = 0.
  - fifo_ren = rst_done && !fifo_empty && (fill - (fire ? OUT_W : 0)) < OUT_W. Guarantees fill stays <= OUT_W-1+CODE_W < ACC_W.
  - Same-cycle order: shift out OUT_W bits on fire, then merge code[len-1:0] at the new fill.
  - Code bits at positions >= len are masked to zero.
  - On a pop with eob=1, the entry's bits are merged and next state = FLUSH.
  - len=0 entries are legal and contribute no bits.
- FLUSH state:
  - fifo_ren = 0.
  - If fill > OUT_W: out_valid=1, out_bits=OUT_W, out_last=0.
  - If fill <= OUT_W: out_valid=1, out_bits=fill, out_last=1. This covers fill=0, which produces a zero-bit last word with out_data=0.
  - On fire with out_last=1: accumulator and fill cleared, err_sticky cleared, state=RUN.
- Error handling:
  - A pop with fifo_rerr=1 sets err_sticky. The entry is still packed.
  - out_err = err_sticky || (the current pop carries fifo_rerr and is being merged into the presented word). The simplest compliant implementation uses err_sticky only, so out_err begins on the word after the errored pop's cycle.
  - Every word from then through the last word of the block reports out_err=1.
- Arithmetic:
  - fill is log2(ACC_W)+1 bits and never exceeds ACC_W-1.
  - The shift-out is a logical right shift by OUT_W.
  - Merge = acc | (masked_code << fill_after_shift).
- A len > CODE_W entry is illegal. An assertion fires, and RTL clamps len to CODE_W.

Decomposition:
- Package cr_huf_comp_pack_pkg:
  - entry struct typedef {eob, len, code}.
  - CODE_W/LEN_W/OUT_W constants.
  - state enum {RUN, FLUSH}.
- Sub-module cr_huf_comp_bit_pack_merge: combinational mask + left-shift + OR of a codeword into the accumulator at a given offset. Shared with future packers.

Test Plan:
- Eight entries len=8, code=8'hA5 (k+1 in the upper nibble optional), eob on the 8th:
  - One word out_data=64'hA5A5A5A5A5A5A5A5.
  - out_bits=64, out_last=1 (fill==64 in FLUSH).
- Entries len=48 code=48'h1, then len=20 code=20'hFFFFF eob:
  - Word0 = bits0=1, bits[63:48]=16'hFFFF, out_last=0.
  - Word1 out_data=4'hF, out_bits=4, out_last=1.
- Single entry len=0 eob=1: one word with out_bits=0, out_data=0, out_last=1.
- out_ready held low 10 cycles with fill>=64:
  - out_data stable.
  - fifo_ren drops once fill-0 >= 64; no pops lost.
  - fill never exceeds 111.
- fifo_rerr=1 on the 2nd of 20 len=16 entries (eob on last):
  - All words from the word after the error through out_last have out_err=1.
  - The next block starts with out_err=0.
- rst_n asserted mid-FLUSH with out_valid=1:
  - out_valid=0 immediately.
  - fifo_ren=0 through the first post-reset edge.
  - Then normal packing resumes from fill=0.
